// File: rtl/sum_bird_pipe.sv
// Pipelined signed add/sub: the carry chain is cut into STAGES chunks behind an operand capture register.
// Latency STAGES cycles after acceptance; a stalled output freezes every stage, so in_ready = !stall.
module sum_bird_pipe #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 2,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   input  logic             in_sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic [WIDTH-1:0] c,
   output logic             of,
   output logic [CNT_W-1:0] ovf_count,
   input  logic             cnt_clr
);

   localparam int CW = WIDTH / STAGES;
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   // a: operand A, b: B already inverted for subtract, r/c: result and carries
   // filled in so far, cy: carry into the next unprocessed chunk.
   typedef struct packed {
      logic             vld;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] r;
      logic [WIDTH-1:0] c;
      logic             cy;
      logic             sat;
   } stage_t;

   // Level 0 holds captured operands; level k holds the result through chunk k-1.
   stage_t st  [STAGES+1];
   stage_t nxt [STAGES+1];

   logic             stall;
   logic             fire;
   logic [CNT_W-1:0] cnt;

   assign stall    = st[STAGES].vld && !out_ready;
   assign in_ready = !stall;
   assign fire     = st[STAGES].vld && out_ready;

   always_comb begin
      logic          cy;
      logic [IW-1:0] idx;
      cy  = 1'b0;
      idx = '0;
      for (int k = 0; k <= STAGES; k++) begin
         nxt[k] = st[k];
      end

      // Operand fields only load on a real beat so idle inputs never reach state.
      nxt[0].vld = in_valid;
      if (in_valid) begin
         nxt[0].a   = in_a;
         nxt[0].b   = in_sub ? ~in_b : in_b;
         nxt[0].r   = '0;
         nxt[0].c   = '0;
         nxt[0].cy  = in_sub;
         nxt[0].sat = in_sat;
      end

      for (int k = 1; k <= STAGES; k++) begin
         nxt[k] = st[k-1];
         cy     = st[k-1].cy;
         for (int i = 0; i < CW; i++) begin
            idx           = IW'((k - 1) * CW + i);
            nxt[k].r[idx] = st[k-1].a[idx] ^ st[k-1].b[idx] ^ cy;
            cy            = (st[k-1].a[idx] & st[k-1].b[idx]) |
                            (cy & (st[k-1].a[idx] ^ st[k-1].b[idx]));
            nxt[k].c[idx] = cy;
         end
         nxt[k].cy = cy;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k <= STAGES; k++) begin
            st[k] <= '0;
         end
      end else if (!stall) begin
         for (int k = 0; k <= STAGES; k++) begin
            st[k] <= nxt[k];
         end
      end
   end

   assign out_valid = st[STAGES].vld;
   assign c         = st[STAGES].c;
   assign of        = st[STAGES].c[WIDTH-1] ^ st[STAGES].c[WIDTH-2];

   // Saturation only rewrites the sum; the direction follows the sign of A.
   always_comb begin
      sum = st[STAGES].r;
      if (st[STAGES].sat && of) begin
         sum = st[STAGES].a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                     : {1'b0, {(WIDTH-1){1'b1}}};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (cnt_clr) begin
         cnt <= '0;
      end else if (fire && of && (cnt != {CNT_W{1'b1}})) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign ovf_count = cnt;

endmodule

// File: tb/tb_sum_bird_pipe.sv
// Directed and randomised checks for sum_bird_pipe at 16/2, 32/4 and 16/1 configurations.
module tb_sum_bird_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        in_valid, in_ready, in_sub, in_sat, out_valid, out_ready, of, cnt_clr;
   logic [15:0] in_a, in_b, sum, c;
   logic [7:0]  ovf_count;

   logic        v32_iv, v32_ir, v32_sub, v32_sat, v32_ov, v32_or, v32_of;
   logic [31:0] v32_a, v32_b, v32_sum, v32_c;
   logic [7:0]  v32_cnt;

   logic        w1_iv, w1_ir, w1_sub, w1_sat, w1_ov, w1_or, w1_of;
   logic [15:0] w1_a, w1_b, w1_sum, w1_c;
   logic [7:0]  w1_cnt;

   logic        zero_clr;

   int n_chk  = 0;
   int n_fail = 0;

   logic [15:0] bp_a [9];
   logic [15:0] bp_b [9];
   logic        bp_sub [9];
   logic        bp_sat [9];
   logic [15:0] bp_s [9];

   logic [64:0] q32 [$];
   logic [32:0] q1 [$];

   sum_bird_pipe #(.WIDTH(16), .STAGES(2), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_sat(in_sat),
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .c(c), .of(of),
      .ovf_count(ovf_count), .cnt_clr(cnt_clr));

   sum_bird_pipe #(.WIDTH(32), .STAGES(4), .CNT_W(8)) u32 (
      .clk(clk), .rst_n(rst_n), .in_valid(v32_iv), .in_ready(v32_ir),
      .in_a(v32_a), .in_b(v32_b), .in_sub(v32_sub), .in_sat(v32_sat),
      .out_valid(v32_ov), .out_ready(v32_or), .sum(v32_sum), .c(v32_c), .of(v32_of),
      .ovf_count(v32_cnt), .cnt_clr(zero_clr));

   sum_bird_pipe #(.WIDTH(16), .STAGES(1), .CNT_W(8)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(w1_iv), .in_ready(w1_ir),
      .in_a(w1_a), .in_b(w1_b), .in_sub(w1_sub), .in_sat(w1_sat),
      .out_valid(w1_ov), .out_ready(w1_or), .sum(w1_sum), .c(w1_c), .of(w1_of),
      .ovf_count(w1_cnt), .cnt_clr(zero_clr));

   // Reference: carries recovered from a ^ b' ^ (a + b' + cin), not from a ripple.
   function automatic void ref_model(input int w, input logic [63:0] a, input logic [63:0] b,
                                     input logic sub, input logic sat,
                                     output logic [63:0] s, output logic [63:0] cv, output logic ov);
      logic [63:0] mask, am, bp, full, x;
      mask = (64'd1 << w) - 64'd1;
      am   = a & mask;
      bp   = sub ? (~b & mask) : (b & mask);
      full = am + bp + {63'd0, sub};
      x    = am ^ bp ^ full;
      cv   = (x >> 1) & mask;
      s    = full & mask;
      ov   = cv[w-1] ^ cv[w-2];
      if (sat && ov) s = a[w-1] ? (64'd1 << (w-1)) : ((64'd1 << (w-1)) - 64'd1);
   endfunction

   function automatic logic [31:0] pick32();
      case ($urandom_range(0, 7))
         0: return 32'h8000_0000;
         1: return 32'h7FFF_FFFF;
         2: return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   function automatic logic [15:0] pick16();
      case ($urandom_range(0, 7))
         0: return 16'h8000;
         1: return 16'h7FFF;
         2: return 16'hFFFF;
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Drives one beat, waits (bounded) for its result and reports latency in edges.
   task automatic run1(input logic [15:0] a, input logic [15:0] b, input logic sub, input logic sat,
                       output logic [15:0] s, output logic [15:0] cv, output logic ofo,
                       output int lat, output bit ok);
      in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; in_sat = sat;
      @(posedge clk); #1;
      in_valid = 1'b0;
      ok = 1'b0; lat = 0; s = '0; cv = '0; ofo = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge clk);
         if (out_valid) begin
            ok = 1'b1; s = sum; cv = c; ofo = of;
         end else begin
            @(posedge clk); #1;
            lat++;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
      n_chk++; if (sum !== 16'h0) begin n_fail++; $display("FAIL rst_sum: got %h expected 0000", sum); end
      n_chk++; if (c !== 16'h0) begin n_fail++; $display("FAIL rst_c: got %h expected 0000", c); end
      n_chk++; if (of !== 1'b0) begin n_fail++; $display("FAIL rst_of: got %b expected 0", of); end
      n_chk++; if (ovf_count !== 8'h0) begin n_fail++; $display("FAIL rst_ovf_count: got %0d expected 0", ovf_count); end
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      tick();
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_add();
      logic [15:0] s, cv; logic o; int lat; bit ok;
      run1(16'h7FFF, 16'hFFC0, 1'b0, 1'b0, s, cv, o, lat, ok);
      n_chk++; if (!ok || lat != 2) begin n_fail++; $display("FAIL add1_latency: got ok=%0d lat=%0d expected ok=1 lat=2", ok, lat); end
      n_chk++; if (s !== 16'h7FBF) begin n_fail++; $display("FAIL add1_sum: got %h expected 7fbf", s); end
      n_chk++; if (cv !== 16'hFFC0) begin n_fail++; $display("FAIL add1_c: got %h expected ffc0", cv); end
      n_chk++; if (o !== 1'b0) begin n_fail++; $display("FAIL add1_of: got %b expected 0", o); end
      run1(16'h0010, 16'h0004, 1'b0, 1'b0, s, cv, o, lat, ok);
      n_chk++; if (!ok || s !== 16'h0014) begin n_fail++; $display("FAIL add2_sum: got %h expected 0014", s); end
      n_chk++; if (cv !== 16'h0000) begin n_fail++; $display("FAIL add2_c: got %h expected 0000", cv); end
      n_chk++; if (o !== 1'b0) begin n_fail++; $display("FAIL add2_of: got %b expected 0", o); end
   endtask

   task automatic test_overflow();
      logic [15:0] s, cv; logic o; int lat; bit ok;
      run1(16'h2000, 16'h7FFF, 1'b0, 1'b0, s, cv, o, lat, ok);
      n_chk++; if (!ok || s !== 16'h9FFF) begin n_fail++; $display("FAIL ovf_wrap_sum: got %h expected 9fff", s); end
      n_chk++; if (cv !== 16'h6000) begin n_fail++; $display("FAIL ovf_wrap_c: got %h expected 6000", cv); end
      n_chk++; if (o !== 1'b1) begin n_fail++; $display("FAIL ovf_wrap_of: got %b expected 1", o); end
      n_chk++; if (ovf_count !== 8'd1) begin n_fail++; $display("FAIL ovf_count1: got %0d expected 1", ovf_count); end
      run1(16'h2000, 16'h7FFF, 1'b0, 1'b1, s, cv, o, lat, ok);
      n_chk++; if (!ok || s !== 16'h7FFF) begin n_fail++; $display("FAIL ovf_sat_sum: got %h expected 7fff", s); end
      n_chk++; if (cv !== 16'h6000) begin n_fail++; $display("FAIL ovf_sat_c: got %h expected 6000", cv); end
      n_chk++; if (o !== 1'b1) begin n_fail++; $display("FAIL ovf_sat_of: got %b expected 1", o); end
      n_chk++; if (ovf_count !== 8'd2) begin n_fail++; $display("FAIL ovf_count2: got %0d expected 2", ovf_count); end
   endtask

   task automatic test_sub();
      logic [15:0] s, cv; logic o; int lat; bit ok;
      run1(16'h8000, 16'h0001, 1'b1, 1'b0, s, cv, o, lat, ok);
      n_chk++; if (!ok || s !== 16'h7FFF) begin n_fail++; $display("FAIL sub_wrap_sum: got %h expected 7fff", s); end
      n_chk++; if (cv !== 16'h8000) begin n_fail++; $display("FAIL sub_wrap_c: got %h expected 8000", cv); end
      n_chk++; if (o !== 1'b1) begin n_fail++; $display("FAIL sub_wrap_of: got %b expected 1", o); end
      run1(16'h8000, 16'h0001, 1'b1, 1'b1, s, cv, o, lat, ok);
      n_chk++; if (!ok || s !== 16'h8000) begin n_fail++; $display("FAIL sub_sat_sum: got %h expected 8000", s); end
      n_chk++; if (o !== 1'b1) begin n_fail++; $display("FAIL sub_sat_of: got %b expected 1", o); end
      run1(16'h0100, 16'h0020, 1'b1, 1'b0, s, cv, o, lat, ok);
      n_chk++; if (!ok || s !== 16'h00E0) begin n_fail++; $display("FAIL sub_plain_sum: got %h expected 00e0", s); end
      n_chk++; if (o !== 1'b0) begin n_fail++; $display("FAIL sub_plain_of: got %b expected 0", o); end
      n_chk++; if (ovf_count !== 8'd4) begin n_fail++; $display("FAIL sub_ovf_count: got %0d expected 4", ovf_count); end
   endtask

   task automatic test_back_to_back();
      bp_a[0] = 16'h7FFF; bp_b[0] = 16'hFFC0; bp_sub[0] = 0; bp_sat[0] = 0; bp_s[0] = 16'h7FBF;
      bp_a[1] = 16'h0010; bp_b[1] = 16'h0004; bp_sub[1] = 0; bp_sat[1] = 0; bp_s[1] = 16'h0014;
      bp_a[2] = 16'h2000; bp_b[2] = 16'h7FFF; bp_sub[2] = 0; bp_sat[2] = 0; bp_s[2] = 16'h9FFF;
      bp_a[3] = 16'h2000; bp_b[3] = 16'h7FFF; bp_sub[3] = 0; bp_sat[3] = 1; bp_s[3] = 16'h7FFF;
      bp_a[4] = 16'h8000; bp_b[4] = 16'h0001; bp_sub[4] = 1; bp_sat[4] = 0; bp_s[4] = 16'h7FFF;
      bp_a[5] = 16'h8000; bp_b[5] = 16'h0001; bp_sub[5] = 1; bp_sat[5] = 1; bp_s[5] = 16'h8000;
      bp_a[6] = 16'h0100; bp_b[6] = 16'h0020; bp_sub[6] = 1; bp_sat[6] = 0; bp_s[6] = 16'h00E0;
      bp_a[7] = 16'hF800; bp_b[7] = 16'hF000; bp_sub[7] = 0; bp_sat[7] = 0; bp_s[7] = 16'hE800;
      bp_a[8] = 16'h0064; bp_b[8] = 16'hFF9C; bp_sub[8] = 0; bp_sat[8] = 0; bp_s[8] = 16'h0000;
      out_ready = 1'b1;
      fork
         begin : driver
            bit acc;
            for (int i = 0; i < 9; i++) begin
               in_valid = 1'b1; in_a = bp_a[i]; in_b = bp_b[i]; in_sub = bp_sub[i]; in_sat = bp_sat[i];
               acc = 1'b0;
               for (int t = 0; t < 20 && !acc; t++) begin
                  @(negedge clk);
                  if (in_ready) acc = 1'b1;
                  @(posedge clk); #1;
               end
               if (!acc) begin n_chk++; n_fail++; $display("FAIL bp_accept_timeout: beat %0d not accepted", i); end
            end
            in_valid = 1'b0;
         end
         begin : monitor
            int idx; bit st_prev; logic [32:0] prev;
            idx = 0; st_prev = 1'b0; prev = '0;
            for (int cyc = 0; cyc < 60 && idx < 9; cyc++) begin
               @(negedge clk);
               if (out_valid && !out_ready) begin
                  n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
                  if (st_prev) begin
                     n_chk++; if ({sum, c, of} !== prev) begin n_fail++; $display("FAIL bp_stable: got %h expected %h", {sum, c, of}, prev); end
                  end
                  st_prev = 1'b1; prev = {sum, c, of};
               end else begin
                  st_prev = 1'b0;
               end
               if (out_valid && out_ready) begin
                  n_chk++; if (sum !== bp_s[idx]) begin n_fail++; $display("FAIL bp_sum%0d: got %h expected %h", idx, sum, bp_s[idx]); end
                  idx++;
               end
               @(posedge clk); #1;
               out_ready = !(cyc >= 3 && cyc < 6);
            end
            n_chk++; if (idx != 9) begin n_fail++; $display("FAIL bp_count: got %0d results expected 9", idx); end
         end
      join
      out_ready = 1'b1;
      @(negedge clk);
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_extra: got out_valid=%b expected 0", out_valid); end
      tick();
   endtask

   task automatic test_reset_mid();
      logic [15:0] s, cv; logic o; int lat; bit ok;
      out_ready = 1'b0;
      in_valid = 1'b1; in_a = 16'h2000; in_b = 16'h7FFF; in_sub = 1'b0; in_sat = 1'b0;
      tick();
      in_a = 16'h0010; in_b = 16'h0004;
      tick();
      in_valid = 1'b0;
      tick();
      @(negedge clk);
      n_chk++; if (out_valid !== 1'b1 || of !== 1'b1) begin n_fail++; $display("FAIL rmid_pre: got out_valid=%b of=%b expected 1 1", out_valid, of); end
      #1 rst_n = 1'b0;
      #1;
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid: got %b expected 0", out_valid); end
      n_chk++; if (sum !== 16'h0 || c !== 16'h0 || of !== 1'b0) begin n_fail++; $display("FAIL rmid_data: got sum=%h c=%h of=%b expected 0 0 0", sum, c, of); end
      n_chk++; if (ovf_count !== 8'd0) begin n_fail++; $display("FAIL rmid_ovf_count: got %0d expected 0", ovf_count); end
      @(posedge clk); #3;
      rst_n = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      run1(16'h0010, 16'h0004, 1'b0, 1'b0, s, cv, o, lat, ok);
      n_chk++; if (!ok || lat != 2) begin n_fail++; $display("FAIL rmid_latency: got ok=%0d lat=%0d expected ok=1 lat=2", ok, lat); end
      n_chk++; if (s !== 16'h0014) begin n_fail++; $display("FAIL rmid_sum: got %h expected 0014", s); end
   endtask

   task automatic test_counter();
      cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
      n_chk++; if (ovf_count !== 8'd0) begin n_fail++; $display("FAIL cnt_clear: got %0d expected 0", ovf_count); end
      out_ready = 1'b1;
      in_valid = 1'b1; in_a = 16'h2000; in_b = 16'h7FFF; in_sub = 1'b0; in_sat = 1'b0;
      repeat (300) tick();
      in_valid = 1'b0;
      repeat (5) tick();
      n_chk++; if (ovf_count !== 8'd255) begin n_fail++; $display("FAIL cnt_saturate: got %0d expected 255", ovf_count); end
      in_valid = 1'b1;
      repeat (3) tick();
      in_valid = 1'b0; cnt_clr = 1'b1;
      @(negedge clk);
      n_chk++; if (!(out_valid && of && out_ready)) begin n_fail++; $display("FAIL cnt_clr_pre: got out_valid=%b of=%b expected 1 1", out_valid, of); end
      tick();
      cnt_clr = 1'b0;
      n_chk++; if (ovf_count !== 8'd0) begin n_fail++; $display("FAIL cnt_clr_wins: got %0d expected 0", ovf_count); end
      repeat (5) tick();
      n_chk++; if (ovf_count !== 8'd2) begin n_fail++; $display("FAIL cnt_after_clr: got %0d expected 2", ovf_count); end
   endtask

   task automatic test_sweep();
      logic [63:0] s, cv; logic ov; logic [64:0] e32; logic [32:0] e1;
      for (int cyc = 0; cyc < 10020; cyc++) begin
         @(negedge clk);
         if (v32_ov && v32_or) begin
            n_chk++;
            if (q32.size() == 0) begin n_fail++; $display("FAIL sw32_extra: unexpected result %h", v32_sum); end
            else begin
               e32 = q32.pop_front();
               if ({v32_of, v32_c, v32_sum} !== e32) begin n_fail++; $display("FAIL sw32_result: got %h expected %h", {v32_of, v32_c, v32_sum}, e32); end
            end
         end
         if (w1_ov && w1_or) begin
            n_chk++;
            if (q1.size() == 0) begin n_fail++; $display("FAIL sw1_extra: unexpected result %h", w1_sum); end
            else begin
               e1 = q1.pop_front();
               if ({w1_of, w1_c, w1_sum} !== e1) begin n_fail++; $display("FAIL sw1_result: got %h expected %h", {w1_of, w1_c, w1_sum}, e1); end
            end
         end
         if (v32_iv && v32_ir) begin
            ref_model(32, {32'd0, v32_a}, {32'd0, v32_b}, v32_sub, v32_sat, s, cv, ov);
            q32.push_back({ov, cv[31:0], s[31:0]});
         end
         if (w1_iv && w1_ir) begin
            ref_model(16, {48'd0, w1_a}, {48'd0, w1_b}, w1_sub, w1_sat, s, cv, ov);
            q1.push_back({ov, cv[15:0], s[15:0]});
         end
         @(posedge clk); #1;
         if (cyc < 10000) begin
            v32_iv = ($urandom_range(0, 3) != 0); v32_a = pick32(); v32_b = pick32();
            v32_sub = 1'($urandom); v32_sat = 1'($urandom); v32_or = ($urandom_range(0, 3) != 0);
            w1_iv = ($urandom_range(0, 3) != 0); w1_a = pick16(); w1_b = pick16();
            w1_sub = 1'($urandom); w1_sat = 1'($urandom); w1_or = ($urandom_range(0, 3) != 0);
         end else begin
            v32_iv = 1'b0; v32_or = 1'b1; w1_iv = 1'b0; w1_or = 1'b1;
         end
      end
      n_chk++; if (q32.size() != 0) begin n_fail++; $display("FAIL sw32_lost: got %0d pending expected 0", q32.size()); end
      n_chk++; if (q1.size() != 0) begin n_fail++; $display("FAIL sw1_lost: got %0d pending expected 0", q1.size()); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_sat = 1'b0;
      out_ready = 1'b1; cnt_clr = 1'b0; zero_clr = 1'b0;
      v32_iv = 1'b0; v32_a = '0; v32_b = '0; v32_sub = 1'b0; v32_sat = 1'b0; v32_or = 1'b1;
      w1_iv = 1'b0; w1_a = '0; w1_b = '0; w1_sub = 1'b0; w1_sat = 1'b0; w1_or = 1'b1;
      test_reset();
      test_add();
      test_overflow();
      test_sub();
      test_back_to_back();
      test_reset_mid();
      test_counter();
      test_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
